// File: rtl/note_trainer_seq.sv
// Note trainer sequencer: plays NUM_NOTES targets, scores PS/2 make codes; train mode replays on miss.
// Latency: key strobe -> CHECK next cycle -> next play_req 2 cycles after strobe; play_req held until play_ack.
module note_trainer_seq #(
  parameter int                       NUM_NOTES  = 7,
  parameter int                       IDX_W      = 3,
  parameter logic [8*NUM_NOTES-1:0]   NOTE_CODES = 56'h34_2B_24_23_21_32_1C,
  parameter logic [7:0]               TRAIN_KEY  = 8'h2C,
  parameter logic [7:0]               GAME_KEY   = 8'h34,
  parameter logic [7:0]               START_KEY  = 8'h29,
  parameter logic [7:0]               ESC_KEY    = 8'h76,
  parameter int                       MAX_MISS   = 3,
  parameter int                       CNT_W      = 5
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [7:0]       ps2_key_data,
  input  logic             ps2_key_pressed,
  input  logic             play_ack,
  output logic             play_req,
  output logic [IDX_W-1:0] play_note_idx,
  output logic             game_mode,
  output logic [2:0]       fsm_state,
  output logic [CNT_W-1:0] correct_count,
  output logic [CNT_W-1:0] miss_count,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_PLAY     = 3'd2,
    S_WAIT_KEY = 3'd3,
    S_CHECK    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] note_idx, note_idx_nxt;
  logic [CNT_W-1:0] correct_nxt, miss_nxt;
  logic [CNT_W-1:0] consec_miss, consec_miss_nxt;
  logic [7:0]       key_q, key_nxt;
  logic             break_pending, break_nxt;
  logic             game_nxt;
  logic             key_valid, esc, hit, advance;
  logic [7:0]       target_code;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Break prefix swallows the following byte; extended prefix is transparent.
  assign key_valid = ps2_key_pressed && !break_pending &&
                     (ps2_key_data != 8'hF0) && (ps2_key_data != 8'hE0);
  assign esc       = key_valid && (ps2_key_data == ESC_KEY);

  always_comb begin
    break_nxt = break_pending;
    if (ps2_key_pressed) begin
      if (ps2_key_data == 8'hF0)      break_nxt = 1'b1;
      else if (ps2_key_data != 8'hE0) break_nxt = 1'b0;
    end
  end

  assign target_code = NOTE_CODES[8*int'(note_idx) +: 8];
  assign hit         = (key_q == target_code);

  always_comb begin
    state_nxt       = state;
    note_idx_nxt    = note_idx;
    correct_nxt     = correct_count;
    miss_nxt        = miss_count;
    consec_miss_nxt = consec_miss;
    key_nxt         = key_q;
    game_nxt        = game_mode;
    advance         = 1'b0;

    if (state != S_IDLE && esc) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_valid && ps2_key_data == TRAIN_KEY) begin
            state_nxt = S_ARMED;
            game_nxt  = 1'b0;
          end else if (key_valid && ps2_key_data == GAME_KEY) begin
            state_nxt = S_ARMED;
            game_nxt  = 1'b1;
          end
        end
        S_ARMED: begin
          if (key_valid && ps2_key_data == START_KEY) begin
            state_nxt       = S_PLAY;
            note_idx_nxt    = '0;
            correct_nxt     = '0;
            miss_nxt        = '0;
            consec_miss_nxt = '0;
          end
        end
        S_PLAY: begin
          if (play_ack) state_nxt = S_WAIT_KEY;
        end
        S_WAIT_KEY: begin
          if (key_valid) begin
            key_nxt   = ps2_key_data;
            state_nxt = S_CHECK;
          end
        end
        S_CHECK: begin
          if (hit) begin
            correct_nxt     = sat_inc(correct_count);
            consec_miss_nxt = '0;
            advance         = 1'b1;
          end else begin
            miss_nxt = sat_inc(miss_count);
            if (game_mode) begin
              advance = 1'b1;
            end else if ((consec_miss + 1'b1) >= CNT_W'(MAX_MISS)) begin
              consec_miss_nxt = '0;
              advance         = 1'b1;
            end else begin
              consec_miss_nxt = consec_miss + 1'b1;
              state_nxt       = S_PLAY;
            end
          end
          if (advance) begin
            if (note_idx == IDX_W'(NUM_NOTES-1)) begin
              state_nxt = S_DONE;
            end else begin
              note_idx_nxt = note_idx + 1'b1;
              state_nxt    = S_PLAY;
            end
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      note_idx      <= '0;
      correct_count <= '0;
      miss_count    <= '0;
      consec_miss   <= '0;
      key_q         <= '0;
      break_pending <= 1'b0;
      game_mode     <= 1'b0;
      play_req      <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      note_idx      <= note_idx_nxt;
      correct_count <= correct_nxt;
      miss_count    <= miss_nxt;
      consec_miss   <= consec_miss_nxt;
      key_q         <= key_nxt;
      break_pending <= break_nxt;
      game_mode     <= game_nxt;
      play_req      <= (state_nxt == S_PLAY);
      done          <= (state_nxt == S_DONE);
    end
  end

  assign play_note_idx = note_idx;
  assign fsm_state     = state;

endmodule

// File: tb/tb_note_trainer_seq.sv
// Bench for note_trainer_seq: stimulus queues expected play/done events, a monitor pops and compares them.
module tb_note_trainer_seq;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       play_ack;
  logic       play_req;
  logic [2:0] play_note_idx;
  logic       game_mode;
  logic [2:0] fsm_state;
  logic [4:0] correct_count;
  logic [4:0] miss_count;
  logic       done;

  note_trainer_seq dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .play_ack        (play_ack),
    .play_req        (play_req),
    .play_note_idx   (play_note_idx),
    .game_mode       (game_mode),
    .fsm_state       (fsm_state),
    .correct_count   (correct_count),
    .miss_count      (miss_count),
    .done            (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    bit is_done;
    int idx;
    int cor;
    int mis;
  } ev_t;

  ev_t q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  logic [7:0] codes [7] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34};

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void exp_play(input int idx);
    ev_t e;
    e.is_done = 1'b0; e.idx = idx; e.cor = 0; e.mis = 0;
    q.push_back(e);
  endfunction

  function automatic void exp_done(input int cor, input int mis);
    ev_t e;
    e.is_done = 1'b1; e.idx = 0; e.cor = cor; e.mis = mis;
    q.push_back(e);
  endfunction

  // Monitor: every rising play_req and every done pulse must match the queue head.
  logic prev_req = 1'b0;

  task automatic pop_check(input bit is_done);
    ev_t e;
    if (q.size() == 0) begin
      chk(is_done ? "unexpected_done" : "unexpected_play", 1, 0);
    end else begin
      e = q.pop_front();
      chk("event_kind", int'(is_done), int'(e.is_done));
      if (!is_done && !e.is_done) chk("play_idx", int'(play_note_idx), e.idx);
      if (is_done && e.is_done) begin
        chk("done_correct", int'(correct_count), e.cor);
        chk("done_miss", int'(miss_count), e.mis);
      end
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (play_req && !prev_req) pop_check(1'b0);
      if (done) pop_check(1'b1);
      prev_req = play_req;
    end
  end

  // All tasks are entered and left on a negedge.
  task automatic send_key(input logic [7:0] b);
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    @(negedge CLOCK_50);
    ps2_key_pressed = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!play_req && n < 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!play_req) chk("play_req_timeout", 0, 1);
  endtask

  task automatic ack();
    wait_req();
    play_ack = 1'b1;
    @(negedge CLOCK_50);
    play_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic start(input logic [7:0] mode_key);
    send_key(mode_key);
    exp_play(0);
    send_key(8'h29);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ps2_key_data = 8'h00;
    ps2_key_pressed = 1'b0;
    play_ack = 1'b0;
    idle(3);
    chk("rst_state", int'(fsm_state), 0);
    chk("rst_play_req", int'(play_req), 0);
    chk("rst_counts", int'(correct_count) + int'(miss_count), 0);
    chk("rst_done_mode", int'(done) + int'(game_mode) + int'(play_note_idx), 0);
    reset = 1'b0;
    idle(2);

    // 1: train, all correct
    start(8'h2C);
    chk("t1_train_mode", int'(game_mode), 0);
    for (int i = 0; i < 7; i++) begin
      ack();
      if (i < 6) exp_play(i + 1); else exp_done(7, 0);
      send_key(codes[i]);
    end
    idle(4);
    chk("t1_back_idle", int'(fsm_state), 0);
    chk("t1_correct_hold", int'(correct_count), 7);

    // 2: train, note 0 wrong three times, then skipped
    start(8'h2C);
    for (int k = 0; k < 3; k++) begin
      ack();
      exp_play(k < 2 ? 0 : 1);
      send_key(8'h1D);
    end
    for (int i = 1; i < 7; i++) begin
      ack();
      if (i < 6) exp_play(i + 1); else exp_done(6, 3);
      send_key(codes[i]);
    end
    idle(4);

    // 3: game, wrong answer on idx2 advances without replay
    start(8'h34);
    chk("t3_game_mode", int'(game_mode), 1);
    for (int i = 0; i < 7; i++) begin
      ack();
      if (i < 6) exp_play(i + 1); else exp_done(6, 1);
      send_key(i == 2 ? 8'h1D : codes[i]);
    end
    idle(4);

    // 4: break code filtering
    start(8'h2C);
    ack();
    send_key(8'hF0);
    send_key(8'h1C);
    idle(3);
    chk("t4_break_no_check", int'(fsm_state), 3);
    exp_play(1);
    send_key(8'hE0);
    send_key(8'h1C);
    wait_req();
    chk("t4_e0_hit_count", int'(correct_count), 1);
    ack();
    send_key(8'h76);
    idle(1);
    chk("t4_esc_idle", int'(fsm_state), 0);

    // 5: ESC coincident with play_ack in PLAY
    start(8'h2C);
    ack();
    exp_play(1);
    send_key(codes[0]);
    wait_req();
    play_ack = 1'b1;
    send_key(8'h76);
    play_ack = 1'b0;
    chk("t5_esc_state", int'(fsm_state), 0);
    chk("t5_esc_play_req", int'(play_req), 0);
    chk("t5_count_hold", int'(correct_count), 1);
    idle(3);
    send_key(8'h34);
    chk("t5_rearm_state", int'(fsm_state), 1);
    chk("t5_rearm_game", int'(game_mode), 1);
    exp_play(0);
    send_key(8'h29);
    for (int i = 0; i < 7; i++) begin
      ack();
      if (i < 6) exp_play(i + 1); else exp_done(7, 0);
      send_key(codes[i]);
    end
    idle(4);

    // 6: async reset in WAIT_KEY at idx4, then keys in PLAY are dropped
    start(8'h2C);
    for (int i = 0; i < 4; i++) begin
      ack();
      exp_play(i + 1);
      send_key(codes[i]);
    end
    ack();
    chk("t6_wait_state", int'(fsm_state), 3);
    chk("t6_wait_idx", int'(play_note_idx), 4);
    #1 reset = 1'b1;
    #1;
    chk("t6_arst_state", int'(fsm_state), 0);
    chk("t6_arst_idx", int'(play_note_idx), 0);
    chk("t6_arst_counts", int'(correct_count) + int'(miss_count), 0);
    chk("t6_arst_misc", int'(play_req) + int'(game_mode) + int'(done), 0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    idle(1);
    start(8'h2C);
    wait_req();
    send_key(8'h1C);
    idle(3);
    chk("t6_play_drop_state", int'(fsm_state), 2);
    chk("t6_play_drop_count", int'(correct_count), 0);
    ack();
    chk("t6_after_ack", int'(fsm_state), 3);
    send_key(8'h76);
    idle(5);

    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
